// File: rtl/wide_uart_tx.sv
// wide_uart_tx: sends a WIDTH-byte word as back-to-back UART frames, least-significant byte first.
// Define WIDE_UART_TX_PARITY_EN to add an even-parity bit after each frame's data bits.
module wide_uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int WIDTH        = 6
) (
    input  logic               masterClock,
    input  logic               reset,
    input  logic [8*WIDTH-1:0] outputData,
    input  logic               transmit,
    output logic               tx,
    output logic               transmitting,
    output logic               done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CLK  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(WIDTH - 1);

`ifdef WIDE_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t             state;
    logic [CW-1:0]      baudCnt;
    logic [2:0]         bitIdx;
    logic [BW-1:0]      byteIdx;
    logic [8*WIDTH-1:0] shiftReg;
    logic               bitEnd;
`ifdef WIDE_UART_TX_PARITY_EN
    logic               parityBit;
`endif

    assign bitEnd = (baudCnt == LAST_CLK);

    always_ff @(posedge masterClock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            baudCnt      <= '0;
            bitIdx       <= '0;
            byteIdx      <= '0;
            shiftReg     <= '0;
            tx           <= 1'b1;
            transmitting <= 1'b0;
            done         <= 1'b0;
`ifdef WIDE_UART_TX_PARITY_EN
            parityBit    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE || bitEnd)
                baudCnt <= '0;
            else
                baudCnt <= baudCnt + CW'(1);

            unique case (state)
                IDLE: begin
                    if (transmit) begin
                        shiftReg     <= outputData;
                        byteIdx      <= '0;
                        bitIdx       <= '0;
                        state        <= START;
                        tx           <= 1'b0;
                        transmitting <= 1'b1;
                    end
                end
                START: begin
                    if (bitEnd) begin
                        state  <= DATA;
                        bitIdx <= '0;
                        tx     <= shiftReg[0];
`ifdef WIDE_UART_TX_PARITY_EN
                        parityBit <= shiftReg[0];
`endif
                    end
                end
                DATA: begin
                    // Shifting one bit per data bit leaves the next byte in [7:0] after eight.
                    if (bitEnd) begin
                        shiftReg <= shiftReg >> 1;
                        if (bitIdx == 3'd7) begin
`ifdef WIDE_UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= parityBit;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bitIdx <= bitIdx + 3'd1;
                            tx     <= shiftReg[1];
`ifdef WIDE_UART_TX_PARITY_EN
                            parityBit <= parityBit ^ shiftReg[1];
`endif
                        end
                    end
                end
`ifdef WIDE_UART_TX_PARITY_EN
                PARITY: begin
                    if (bitEnd) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bitEnd) begin
                        if (byteIdx != LAST_BYTE) begin
                            byteIdx <= byteIdx + BW'(1);
                            state   <= START;
                            tx      <= 1'b0;
                        end else begin
                            state        <= IDLE;
                            transmitting <= 1'b0;
                            done         <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wide_uart_tx.sv
// tb_wide_uart_tx: directed checks of wide_uart_tx waveforms, done pulses and reset behaviour.
// A second default-sized instance is decoded by a simple bench-side UART receiver.
module tb_wide_uart_tx;
    localparam int CPB  = 4;
    localparam int W    = 2;
    localparam int BCPB = 104;
    localparam int BW   = 6;
`ifdef WIDE_UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int WORDCYC = W * FB * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        transmit = 1'b0;
    logic [15:0] outputData = '0;
    logic        tx, transmitting, done;

    logic        rstBig = 1'b1;
    logic        transmitBig = 1'b0;
    logic [47:0] dataBig = '0;
    logic        txBig, transmittingBig, doneBig;

    int checks = 0;
    int errors = 0;
    int bigBusy = 0;

    logic [255:0] txv, expv;
    int busy, nDone, firstDone, lastDone, t;
    logic [7:0]  rxByte;
    logic [47:0] bigWord = 48'h0123456789AB;

    always #5 clk = ~clk;

    wide_uart_tx #(.CLKS_PER_BIT(CPB), .WIDTH(W)) dut (
        .masterClock(clk), .reset(rst), .outputData(outputData),
        .transmit(transmit), .tx(tx), .transmitting(transmitting), .done(done)
    );

    wide_uart_tx dutBig (
        .masterClock(clk), .reset(rstBig), .outputData(dataBig),
        .transmit(transmitBig), .tx(txBig), .transmitting(transmittingBig), .done(doneBig)
    );

    always @(negedge clk) if (transmittingBig) bigBusy++;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic expBit(input logic [15:0] w, input int k);
        int b, f;
        logic [7:0] by;
        b  = k / (FB * CPB);
        f  = (k % (FB * CPB)) / CPB;
        by = w[8*b +: 8];
        if (f == 0) return 1'b0;
        if (f <= 8) return by[f-1];
        if (FB == 11 && f == 9) return ^by;
        return 1'b1;
    endfunction

    function automatic logic [255:0] buildExp(input logic [15:0] w, input logic twice);
        logic [255:0] v;
        v = '1;
        for (int k = 0; k < 256; k++) begin
            if (k < WORDCYC)
                v[k] = expBit(w, k);
            else if (twice && k > WORDCYC && k <= 2*WORDCYC)
                v[k] = expBit(w, k - WORDCYC - 1);
        end
        return v;
    endfunction

    task automatic runWord(input logic [15:0] w, input int glitchAt, input logic hold,
                           input int cycles);
        txv = '1; busy = 0; nDone = 0; firstDone = -1; lastDone = -1;
        @(negedge clk);
        outputData = w;
        transmit = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (!hold || k == WORDCYC + 1) transmit = 1'b0;
            if (k == glitchAt) begin
                transmit = 1'b1;
                outputData = 16'hFFFF;
            end
            txv[k] = tx;
            if (transmitting) busy++;
            if (done) begin
                nDone++;
                if (firstDone < 0) firstDone = k;
                lastDone = k;
            end
        end
        transmit = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rstTx", 256'(tx), 256'(1));
        check("rstTransmitting", 256'(transmitting), 256'(0));
        check("rstDone", 256'(done), 256'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        runWord(16'hA55A, -1, 1'b0, WORDCYC + 6);
        check("w1Wave", txv, buildExp(16'hA55A, 1'b0));
        check("w1Busy", 256'(busy), 256'(WORDCYC));
        check("w1DoneCnt", 256'(nDone), 256'(1));
        check("w1DoneAt", 256'(firstDone), 256'(WORDCYC));
        repeat (3) @(negedge clk);

        runWord(16'hA55A, 20, 1'b0, WORDCYC + 6);
        check("w2Wave", txv, buildExp(16'hA55A, 1'b0));
        check("w2DoneCnt", 256'(nDone), 256'(1));
        check("w2Busy", 256'(busy), 256'(WORDCYC));
        repeat (3) @(negedge clk);

        runWord(16'h0001, -1, 1'b1, 2*WORDCYC + 4);
        check("b2bWave", txv, buildExp(16'h0001, 1'b1));
        check("b2bDoneCnt", 256'(nDone), 256'(2));
        check("b2bDoneGap", 256'(lastDone - firstDone), 256'(WORDCYC + 1));
        repeat (3) @(negedge clk);

`ifdef WIDE_UART_TX_PARITY_EN
        runWord(16'h0307, -1, 1'b0, WORDCYC + 6);
        check("parWave", txv, buildExp(16'h0307, 1'b0));
        check("parBusy", 256'(busy), 256'(2*11*CPB));
        repeat (3) @(negedge clk);
`endif

        @(negedge clk);
        outputData = 16'hA55A;
        transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midRstTx", 256'(tx), 256'(1));
        check("midRstTransmitting", 256'(transmitting), 256'(0));
        nDone = 0;
        repeat (WORDCYC) begin
            @(negedge clk);
            if (done) nDone++;
        end
        check("midRstNoDone", 256'(nDone), 256'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        runWord(16'h1234, -1, 1'b0, WORDCYC + 6);
        check("postRstWave", txv, buildExp(16'h1234, 1'b0));
        check("postRstDoneCnt", 256'(nDone), 256'(1));

        rstBig = 1'b0;
        repeat (2) @(negedge clk);
        dataBig = bigWord;
        transmitBig = 1'b1;
        @(negedge clk);
        transmitBig = 1'b0;
        dataBig = '0;
        for (int b = 0; b < BW; b++) begin
            t = 0;
            while (txBig && t < 4*FB*BCPB) begin
                @(negedge clk);
                t++;
            end
            repeat (BCPB/2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BCPB) @(negedge clk);
                rxByte[i] = txBig;
            end
            check($sformatf("rxByte%0d", b), 256'(rxByte), 256'(bigWord[8*b +: 8]));
            repeat ((FB - 9) * BCPB) @(negedge clk);
        end
        t = 0;
        while (transmittingBig && t < 4*FB*BCPB) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        check("bigBusy", 256'(bigBusy), 256'(BW*FB*BCPB));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
